// File: rtl/data_unpacker_pkg.sv
// Shared sizing helpers and state encoding for the wide-to-narrow unpacker.
package data_unpacker_pkg;

  // Integer ceiling division, used to size the number of narrow slices.
  function automatic int ceil_a_by_b(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Ceiling log2: bits needed to index n distinct values (0 for n<=1).
  function automatic int C_LOG_2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } unpack_state_e;

endpackage

// File: rtl/data_unpacker.sv
// Width-down converter: one wide word in, OUT_NUM_DATA narrow slices out,
// least-significant slice first, with no bubble between wide words.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter  int IN_WIDTH     = 128,
  parameter  int OUT_WIDTH    = 64,
  localparam int OUT_NUM_DATA = (ceil_a_by_b(IN_WIDTH, OUT_WIDTH) < 1) ? 1
                                : ceil_a_by_b(IN_WIDTH, OUT_WIDTH),
  localparam int DATA_COUNT_W = (C_LOG_2(OUT_NUM_DATA) < 1) ? 1
                                : C_LOG_2(OUT_NUM_DATA)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_write_req,
  output logic                 s_write_ready,
  input  logic [IN_WIDTH-1:0]  s_write_data,
  input  logic                 s_write_last,
  output logic                 m_write_req,
  input  logic                 m_write_ready,
  output logic [OUT_WIDTH-1:0] m_write_data,
  output logic                 m_write_last
);

  // Buffer is widened to a whole number of slices so the top slice reads
  // zero-padded bits instead of running off the end of the wide word.
  localparam int PAD_W = OUT_NUM_DATA * OUT_WIDTH;
  localparam logic [DATA_COUNT_W-1:0] CNT_MAX = DATA_COUNT_W'(OUT_NUM_DATA - 1);

  unpack_state_e           state_q, state_d;
  logic [DATA_COUNT_W-1:0] cnt_q, cnt_d;
  logic [PAD_W-1:0]        buf_q;
  logic                    last_q;
  logic                    load;
  logic                    valid;
  logic                    at_end;
  logic                    in_fire;
  logic                    out_fire;

  assign valid    = (state_q == ST_BUSY);
  assign at_end   = (cnt_q == CNT_MAX);
  // Accept a new word when idle, or when the final slice leaves this cycle;
  // this is the only combinational path (m_write_ready -> s_write_ready).
  assign s_write_ready = reset && (!valid || (at_end && m_write_ready));
  assign in_fire  = s_write_req && s_write_ready;
  assign out_fire = valid && m_write_ready;

  assign m_write_req  = valid;
  assign m_write_data = buf_q[cnt_q*OUT_WIDTH +: OUT_WIDTH];
  assign m_write_last = valid && last_q && at_end;

  // Next-state: advance the slice index, reload or drain after the last slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_BUSY: begin
        if (out_fire) begin
          if (!at_end) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (in_fire) load = 1'b1;
            else         state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  // State and slice index; reset discards any partially emitted word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the wide word (zero-extended into the padded buffer) and its last tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q  <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      buf_q  <= PAD_W'(s_write_data);
      last_q <= s_write_last;
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Scoreboard bench: three unpacker configurations (128/64, 96/64, 64/64),
// each with its own driver, expected-slice queue and output monitor.
module tb_data_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  genvar g;
  for (g = 0; g < 3; g++) begin : cfg
    localparam int IW = (g == 0) ? 128 : (g == 1) ? 96 : 64;
    localparam int N  = (IW + 63) / 64;

    logic          reset, s_req, s_ready, s_last, m_req, m_ready, m_last;
    logic [IW-1:0] s_data;
    logic [63:0]   m_data;
    logic          fin = 1'b0;

    exp_t        q[$];
    int          fires = 0;
    int          last_fire_cyc = 0;
    logic        stall_q = 1'b0;
    logic [63:0] stall_d;
    logic        stall_l;

    data_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .s_write_req   (s_req),
      .s_write_ready (s_ready),
      .s_write_data  (s_data),
      .s_write_last  (s_last),
      .m_write_req   (m_req),
      .m_write_ready (m_ready),
      .m_write_data  (m_data),
      .m_write_last  (m_last)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cfg%0d %s: got %h expected %h", g, nm, act, exp);
      end
    endtask

    // Reference: the word truncated to IW bits, cut into 64-bit pieces from
    // bit 0 upward; last tag only on the final piece of a tagged word.
    function automatic void push_word(input logic [127:0] w, input logic lst);
      logic [127:0] z;
      exp_t e;
      z = '0;
      for (int b = 0; b < IW; b++) z[b] = w[b];
      for (int k = 0; k < N; k++) begin
        e.d = 64'(z >> (64 * k));
        e.l = lst && (k == N - 1);
        q.push_back(e);
      end
    endfunction

    task automatic send(input logic [127:0] w, input logic lst, input bit rnd, output int acc);
      int budget;
      budget = 0;
      acc = -1;
      s_req  = 1'b1;
      s_data = w[IW-1:0];
      s_last = lst;
      while (acc < 0) begin
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (s_ready) begin
          push_word(w, lst);
          acc = cyc;
        end
        @(posedge clk); #1;
        budget++;
        if (acc < 0 && budget > 300) begin
          chk("accept_timeout", 64'(budget), 64'd0);
          acc = cyc;
        end
      end
      s_req = 1'b0;
    endtask

    task automatic drain(input bit rnd);
      int budget;
      budget = 0;
      while (q.size() != 0 && budget < 600) begin
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        budget++;
      end
      chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    // Monitor: pop and compare on every output fire; while stalled the
    // presented slice must not change.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (reset) begin
          if (stall_q && m_req) begin
            chk("hold_data", m_data, stall_d);
            chk("hold_last", 64'(m_last), 64'(stall_l));
          end
          if (m_req && m_ready) begin
            if (q.size() == 0) begin
              chk("unexpected_slice", m_data, 64'd0);
            end else begin
              e = q.pop_front();
              chk("slice_data", m_data, e.d);
              chk("slice_last", 64'(m_last), 64'(e.l));
              fires++;
              last_fire_cyc = cyc;
            end
          end
          stall_q = m_req && !m_ready;
          stall_d = m_data;
          stall_l = m_last;
        end else begin
          stall_q = 1'b0;
        end
      end
    end

    // Driver: reset, directed word, back-to-back stream, random stalls,
    // mid-word reset.
    initial begin
      int acc, a0, f0;
      logic [127:0] w;
      reset = 1'b0; s_req = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_req", 64'(m_req), 64'd0);
      chk("rst_m_data", m_data, 64'd0);
      chk("rst_m_last", 64'(m_last), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("s_ready_after_rst", 64'(s_ready), 64'd1);

      // Directed word from the pattern table.
      if (g == 0)      w = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
      else if (g == 1) w = 128'h0000_0000_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC;
      else             w = 128'h0123_4567_89AB_CDEF;
      send(w, 1'b0, 1'b0, acc);
      @(negedge clk);
      repeat (N - 1) @(negedge clk);
      chk("s_ready_last_slice", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      drain(1'b0);

      // Four back-to-back words: 4*N fires in consecutive cycles.
      f0 = fires;
      a0 = 0;
      for (int i = 0; i < 4; i++) begin
        send({$urandom, $urandom, $urandom, $urandom}, (i == 3), 1'b0, acc);
        if (i == 0) a0 = acc;
      end
      drain(1'b0);
      chk("stream_fires", 64'(fires - f0), 64'(4 * N));
      chk("stream_no_gap", 64'(last_fire_cyc), 64'(a0 + 4 * N));

      // Random downstream stalls, random idles and last tags.
      for (int i = 0; i < 12; i++) begin
        send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, acc);
        repeat ($urandom_range(0, 2)) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      drain(1'b1);

      // Reset after slice 0 has left: partial word is dropped.
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, acc);
      @(posedge clk); #1;
      m_ready = 1'b0;
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      chk("midrst_m_req", 64'(m_req), 64'd0);
      chk("midrst_s_ready", 64'(s_ready), 64'd0);
      chk("midrst_m_data", m_data, 64'd0);
      q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, acc);
      drain(1'b0);
      fin = 1'b1;
    end
  end

  initial begin
    int budget;
    budget = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    checks++;
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      fails++;
      $display("FAIL global_timeout: drivers done %b%b%b expected 111",
               cfg[2].fin, cfg[1].fin, cfg[0].fin);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_unpacker.md
# data_unpacker

Width-down converter that splits each wide IN_WIDTH word into OUT_NUM_DATA narrow OUT_WIDTH words, least-significant slice first. It is the read-side counterpart of the write-path packer: wide words from memory or an upstream wide bus enter here, and narrow operand words leave toward the compute array. Both sides use req/ready handshakes. The block sustains one narrow word per cycle with no bubbles between consecutive wide words.

## Interface

Parameters:
- IN_WIDTH, 128: width of the wide input word.
- OUT_WIDTH, 64: width of the narrow output word.
- OUT_NUM_DATA, derived: ceil_a_by_b(IN_WIDTH, OUT_WIDTH), minimum 1.
- DATA_COUNT_W, derived: `C_LOG_2(OUT_NUM_DATA)`, minimum 1.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low (0 = reset).
- s_write_req  in  1  upstream wide word valid.
- s_write_ready  out  1  block accepts a wide word this cycle.
- s_write_data  in  IN_WIDTH  wide word.
- s_write_last  in  1  wide word is the last one of a transfer.
- m_write_req  out  1  narrow word valid.
- m_write_ready  in  1  downstream accepts a narrow word.
- m_write_data  out  OUT_WIDTH  current narrow slice.
- m_write_last  out  1  final slice of a wide word tagged s_write_last.

## Operation

- Input fire: s_write_req && s_write_ready. Output fire: m_write_req && m_write_ready.
- State:
  - buf (IN_WIDTH, holds the captured word).
  - last_q (captured s_write_last).
  - valid (buf holds an unfinished word).
  - cnt (DATA_COUNT_W, index of the current slice).
- Two states, EMPTY (valid=0) and BUSY (valid=1).
  - EMPTY -> BUSY on input fire: buf, last_q captured; cnt<=0.
  - BUSY, output fire, cnt<OUT_NUM_DATA-1: cnt<=cnt+1.
  - BUSY, output fire, cnt==OUT_NUM_DATA-1:
    - Input fire in the same cycle: stay BUSY, load the new word, cnt<=0.
    - Otherwise: go to EMPTY, cnt<=0.
- s_write_ready = reset && (!valid || (cnt==OUT_NUM_DATA-1 && m_write_ready)). This is combinational from m_write_ready, which is the only comb path through the block.
- m_write_req = valid.
- m_write_data = buf[cnt*OUT_WIDTH +: OUT_WIDTH].
  - When IN_WIDTH is not a multiple of OUT_WIDTH, the top slice is zero-padded in its upper bits.
  - If IN_WIDTH <= OUT_WIDTH, OUT_NUM_DATA=1 and the word is zero-extended.
- m_write_last = valid && last_q && (cnt==OUT_NUM_DATA-1).
- With m_write_ready low, m_write_data, m_write_last and cnt hold stable. No slice is skipped or repeated.
- When OUT_NUM_DATA=1, the block behaves as a one-entry register stage with full throughput.

## Timing

- Reset low (asynchronous, immediate):
  - valid=0, cnt=0, buf=0, last_q=0.
  - m_write_req=0, m_write_data=0, m_write_last=0, s_write_ready=0.
- s_write_ready rises in the first cycle with reset high.
- Latency: a word accepted on edge N presents slice 0 in cycle N+1.
- Throughput: OUT_NUM_DATA output fires per wide word. Back-to-back wide words give continuous m_write_req with no idle cycle.
- Reset asserted mid-word: the partial word is discarded and no further slices are emitted. After release the block is in EMPTY.
- When both sides stall, all state holds indefinitely.

## Structure

- ceil_a_by_b and `C_LOG_2 belong in the shared dw_params include/package. Do not duplicate them locally.
- Single flat module, no sub-module. The slice mux is an indexed part-select.

## Test plan

- IN=128, OUT=64. Send 0x1111..._2222... with m_write_ready=1 -> outputs 0x2222_2222_2222_2222 then 0x1111_1111_1111_1111 in consecutive cycles; s_write_ready=1 in the second cycle.
- Stream 4 back-to-back wide words, with s_write_last on the 4th -> 8 consecutive narrow fires with no gap; m_write_last only on the 8th.
- Toggle m_write_ready randomly 50% on the same 4 words -> identical 8-word sequence; no drop or duplicate; data stable while stalled.
- IN=96, OUT=64, input 0xAAAAAAAA_BBBBBBBB_CCCCCCCC -> 0xBBBBBBBB_CCCCCCCC, then 0x00000000_AAAAAAAA.
- Assert reset after slice 0 of a 128-bit word -> m_write_req=0 immediately. After release the next word's slice 0 appears first.
- IN=64, OUT=64 -> one output per input, one-cycle latency, full throughput.
